muldiv_seq_ctrl: RTL and testbench
==================================

MULDIV_SEQ_CTRL -- requirements
Module: muldiv_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand width; the block SHALL issue exactly WIDTH iteration steps per operation; legal range 2..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH): step-index width; SHALL be derived from WIDTH and not overridden.
REQ-003 Port clk, input, 1: clock; all state updates on rising edge.
REQ-004 Port Reset, input, 1: reset, synchronous, active-high.
REQ-005 Port Run, input, 1: start request; sampled only in IDLE or DONE.
REQ-006 Port Mode, input, 1: 0 = multiply, 1 = divide; captured on Run acceptance.
REQ-007 Port Signed, input, 1: signed operation request; captured on Run acceptance.
REQ-008 Port Ack, input, 1: consumer acknowledges result; sampled only in DONE.
REQ-009 Port load_en, output, 1: datapath loads operands this cycle.
REQ-010 Port step_en, output, 1: datapath performs one shift/add (mul) or shift/subtract (div) step this cycle.
REQ-011 Port step_idx, output, CNT_W: index of the current step, 0..WIDTH-1.
REQ-012 Port fix_en, output, 1: datapath applies sign correction this cycle.
REQ-013 Port mode_q / signed_q, output, 1 each: captured Mode/Signed, stable from LOAD through DONE.
REQ-014 Port pre_finish, output, 1: high during the final step cycle only.
REQ-015 Port Ready, output, 1: result valid; high throughout DONE.
REQ-016 Port busy, output, 1: high in LOAD, ITER and FIX.

Function
REQ-017 States IDLE, LOAD, ITER, FIX, DONE; outputs SHALL be registered or decoded from state only, with no combinational path from Run/Ack.
REQ-018 IDLE: Run=1 at an edge SHALL move to LOAD and capture Mode/Signed; Run=0 holds IDLE.
REQ-019 LOAD SHALL last exactly one cycle with load_en=1, then enter ITER with step_idx=0.
REQ-020 ITER SHALL assert step_en every cycle, incrementing step_idx by 1 per cycle for exactly WIDTH cycles (0..WIDTH-1).
REQ-021 pre_finish SHALL be 1 only when state=ITER and step_idx=WIDTH-1.
REQ-022 After step WIDTH-1: go to FIX if signed_q=1 and the fix-up feature is compiled in, else to DONE.
REQ-023 FIX SHALL last exactly one cycle with fix_en=1, then enter DONE.
REQ-024 Latency: Run sampled at edge k SHALL give Ready=1 from edge k+WIDTH+2 (no FIX) or k+WIDTH+3 (FIX).
REQ-025 DONE: Ready=1 and step_idx held at WIDTH-1. Ack=1 returns to IDLE. Run=1 (with or without Ack) enters LOAD directly, capturing new Mode/Signed; Run takes priority over Ack.
REQ-026 Run asserted in LOAD, ITER or FIX SHALL be ignored and SHALL NOT be queued.
REQ-027 The step counter SHALL NOT wrap; it saturates at WIDTH-1 outside ITER.

Reset
REQ-028 Reset=1 at an edge SHALL force IDLE from any state, including mid-ITER, and clear step_idx, mode_q, signed_q, load_en, step_en, fix_en, pre_finish, Ready and busy to 0.
REQ-029 Reset SHALL dominate Run and Ack in the same cycle.

Configuration
REQ-030 Macro MULDIV_SIGN_FIXUP_EN: when defined, the FIX state exists and signed operations take WIDTH+3 cycles. When undefined, FIX is absent, fix_en is tied 0, signed_q is still captured, and all operations take WIDTH+2 cycles.

Structure
REQ-031 Package muldiv_pkg SHALL hold the state enum typedef, MODE_MUL/MODE_DIV constants, and the default WIDTH constant.
REQ-032 Sub-module muldiv_step_counter (clear, enable, saturating CNT_W counter with last-step flag) SHALL implement step_idx and pre_finish.

Verification
REQ-033 WIDTH=4, Mode=0, Signed=0, Run pulse at edge 0 -> load_en in cycle 1; step_en in cycles 2-5 with step_idx 0,1,2,3; pre_finish in cycle 5 only; Ready=1 from edge 6.
REQ-034 WIDTH=4, Signed=1, macro defined -> fix_en in cycle 6 only and Ready from edge 7; with macro undefined -> Ready from edge 6 and fix_en never set.
REQ-035 WIDTH=32, Reset asserted at step_idx=17 -> next cycle all outputs 0 and state IDLE; a following Run gives Ready exactly 34 cycles later.
REQ-036 In DONE, Run=1 and Ack=1 together with Mode=1 -> LOAD next cycle, Ready=0, and mode_q=1.
REQ-037 Run held high continuously through ITER -> no restart; step_idx runs 0..WIDTH-1 once, then DONE, then immediate LOAD.
REQ-038 In DONE, Ack=1 and Run=0 -> IDLE next cycle with Ready=0; Ready held 1 for 10 cycles while Ack=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, mode constants and default width for the mul/div sequencer.
package muldiv_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;
    localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// muldiv_seq_ctrl_if: request/acknowledge handshake and datapath control strobes of the mul/div sequencer.
interface muldiv_seq_ctrl_if #(
    parameter int WIDTH = muldiv_pkg::DEF_WIDTH
);
    localparam int CNT_W = $clog2(WIDTH);
    logic Run;
    logic Mode;
    logic Signed;
    logic Ack;
    logic load_en;
    logic step_en;
    logic [CNT_W-1:0] step_idx;
    logic fix_en;
    logic mode_q;
    logic signed_q;
    logic pre_finish;
    logic Ready;
    logic busy;
    modport master (
        output Run, Mode, Signed, Ack,
        input load_en, step_en, step_idx, fix_en, mode_q, signed_q, pre_finish, Ready, busy
    );
    modport slave (
        input Run, Mode, Signed, Ack,
        output load_en, step_en, step_idx, fix_en, mode_q, signed_q, pre_finish, Ready, busy
    );
endinterface

// File: rtl/muldiv_seq_ctrl_step_counter.sv
// muldiv_step_counter: clearable step index that counts up to WIDTH-1 and holds there, flagging the last step.
module muldiv_step_counter #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);
    assign last = cnt == CNT_W'(WIDTH - 1);
    always_ff @(posedge clk)
        cnt <= clear ? '0 : (en && !last) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: sequencer for an iterative multiply/divide datapath (load, WIDTH steps, optional sign fix-up).
// Define MULDIV_SIGN_FIXUP_EN to add the one-cycle sign-correction state after signed operations.
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input logic              clk,
    input logic              Reset,
    muldiv_seq_ctrl_if.slave bus
);
`ifdef MULDIV_SIGN_FIXUP_EN
    localparam bit FIX_EN = 1'b1;
`else
    localparam bit FIX_EN = 1'b0;
`endif
    state_t state, nxt;
    logic start, last;
    assign start = (state == IDLE || state == DONE) && bus.Run;
    // Run wins over Ack in DONE so back-to-back operations need no idle cycle.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.Run ? LOAD : IDLE;
            LOAD:    nxt = ITER;
            ITER:    nxt = !last ? ITER : (FIX_EN && bus.signed_q) ? FIX : DONE;
            FIX:     nxt = DONE;
            DONE:    nxt = bus.Run ? LOAD : bus.Ack ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= IDLE;
            bus.load_en  <= 1'b0;
            bus.step_en  <= 1'b0;
            bus.fix_en   <= 1'b0;
            bus.Ready    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.mode_q   <= 1'b0;
            bus.signed_q <= 1'b0;
        end else begin
            state        <= nxt;
            bus.load_en  <= nxt == LOAD;
            bus.step_en  <= nxt == ITER;
            bus.fix_en   <= FIX_EN && nxt == FIX;
            bus.Ready    <= nxt == DONE;
            bus.busy     <= nxt == LOAD || nxt == ITER || nxt == FIX;
            bus.mode_q   <= start ? bus.Mode : bus.mode_q;
            bus.signed_q <= start ? bus.Signed : bus.signed_q;
        end
    end
    muldiv_step_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .clear(Reset || start),
        .en   (state == ITER),
        .cnt  (bus.step_idx),
        .last (last)
    );
    assign bus.pre_finish = bus.step_en && last;
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// tb_muldiv_seq_ctrl: table-driven and scoreboarded checks of the mul/div sequencer at WIDTH 4 and 32.
module tb_muldiv_seq_ctrl;
    import muldiv_pkg::*;
    localparam int W = 4;
`ifdef MULDIV_SIGN_FIXUP_EN
    localparam bit FIX = 1'b1;
`else
    localparam bit FIX = 1'b0;
`endif
    typedef struct {
        logic mode;
        logic sgn;
        int   lat;
        logic fix;
    } vec_t;
    logic clk = 1'b0;
    logic rst4, rst32;
    int tests = 0;
    int failed = 0;
    vec_t q[$];
    vec_t tbl[5];
    muldiv_seq_ctrl_if #(.WIDTH(W)) b4 ();
    muldiv_seq_ctrl_if #(.WIDTH(32)) b32 ();
    muldiv_seq_ctrl #(.WIDTH(W)) dut4 (.clk(clk), .Reset(rst4), .bus(b4));
    muldiv_seq_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .Reset(rst32), .bus(b32));
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic m, input logic s, input int w);
        vec_t v;
        v.mode = m;
        v.sgn  = s;
        v.fix  = FIX && s;
        v.lat  = w + 2 + (v.fix ? 1 : 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input vec_t v, input logic a);
        b4.Run    = 1'b1;
        b4.Mode   = v.mode;
        b4.Signed = v.sgn;
        b4.Ack    = a;
        q.push_back(v);
    endtask

    task automatic watch(input bit hold);
        vec_t e;
        int n;
        int fixes;
        e = q[0];
        fixes = 0;
        for (n = 1; n <= 40; n++) begin
            tick;
            if (!hold) b4.Run = 1'b0;
            b4.Ack = 1'b0;
            chk($sformatf("load_en@%0d", n), b4.load_en, n == 1);
            chk($sformatf("step_en@%0d", n), b4.step_en, n >= 2 && n <= W + 1);
            chk($sformatf("step_idx@%0d", n), b4.step_idx, n == 1 ? 0 : n <= W + 1 ? n - 2 : W - 1);
            chk($sformatf("pre_finish@%0d", n), b4.pre_finish, n == W + 1);
            chk($sformatf("fix_en@%0d", n), b4.fix_en, e.fix && n == W + 2);
            chk($sformatf("busy@%0d", n), b4.busy, n < e.lat);
            chk($sformatf("mode_q@%0d", n), b4.mode_q, e.mode);
            chk($sformatf("signed_q@%0d", n), b4.signed_q, e.sgn);
            fixes += int'(b4.fix_en === 1'b1);
            if (b4.Ready === 1'b1) break;
        end
        e = q.pop_front();
        chk("latency", n, e.lat);
        chk("fix_cycles", fixes, e.fix);
    endtask

    task automatic ack_done;
        b4.Ack = 1'b1;
        tick;
        b4.Ack = 1'b0;
        chk("ack_ready", b4.Ready, 0);
        chk("ack_busy", b4.busy, 0);
        chk("ack_load", b4.load_en, 0);
    endtask

    initial begin
        int c;
        tbl[0] = mk(MODE_MUL, 1'b0, W);
        tbl[1] = mk(MODE_DIV, 1'b0, W);
        tbl[2] = mk(MODE_MUL, 1'b1, W);
        tbl[3] = mk(MODE_DIV, 1'b1, W);
        tbl[4] = mk(MODE_MUL, 1'b0, W);
        {b4.Run, b4.Mode, b4.Signed, b4.Ack} = 4'b1111;
        {b32.Run, b32.Mode, b32.Signed, b32.Ack} = 4'b0;
        rst4 = 1'b1;
        rst32 = 1'b1;
        tick;
        chk("rst_load_en", b4.load_en, 0);
        chk("rst_step_en", b4.step_en, 0);
        chk("rst_step_idx", b4.step_idx, 0);
        chk("rst_fix_en", b4.fix_en, 0);
        chk("rst_mode_q", b4.mode_q, 0);
        chk("rst_signed_q", b4.signed_q, 0);
        chk("rst_pre_finish", b4.pre_finish, 0);
        chk("rst_ready", b4.Ready, 0);
        chk("rst_busy", b4.busy, 0);
        rst4 = 1'b0;
        rst32 = 1'b0;
        {b4.Run, b4.Mode, b4.Signed, b4.Ack} = 4'b0;
        tick;
        chk("idle_hold", b4.busy, 0);
        foreach (tbl[i]) begin
            issue(tbl[i], 1'b0);
            watch(1'b0);
            ack_done;
        end
        issue(mk(MODE_MUL, 1'b1, W), 1'b0);
        watch(1'b0);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk($sformatf("ready_hold%0d", i), b4.Ready, 1);
        end
        ack_done;
        issue(mk(MODE_MUL, 1'b0, W), 1'b0);
        watch(1'b0);
        issue(mk(MODE_DIV, 1'b1, W), 1'b1);
        watch(1'b0);
        ack_done;
        issue(mk(MODE_MUL, 1'b0, W), 1'b0);
        watch(1'b1);
        issue(mk(MODE_DIV, 1'b0, W), 1'b0);
        watch(1'b0);
        ack_done;
        b32.Run = 1'b1;
        b32.Mode = 1'b1;
        b32.Signed = 1'b1;
        tick;
        b32.Run = 1'b0;
        for (int i = 0; i < 40 && !(b32.step_en === 1'b1 && b32.step_idx == 17); i++) tick;
        chk("w32_idx17", b32.step_idx, 17);
        rst32 = 1'b1;
        b32.Run = 1'b1;
        b32.Ack = 1'b1;
        tick;
        rst32 = 1'b0;
        b32.Run = 1'b0;
        b32.Ack = 1'b0;
        chk("w32_rst_load_en", b32.load_en, 0);
        chk("w32_rst_step_en", b32.step_en, 0);
        chk("w32_rst_step_idx", b32.step_idx, 0);
        chk("w32_rst_fix_en", b32.fix_en, 0);
        chk("w32_rst_mode_q", b32.mode_q, 0);
        chk("w32_rst_signed_q", b32.signed_q, 0);
        chk("w32_rst_pre_finish", b32.pre_finish, 0);
        chk("w32_rst_ready", b32.Ready, 0);
        chk("w32_rst_busy", b32.busy, 0);
        tick;
        chk("w32_idle_busy", b32.busy, 0);
        chk("w32_idle_load", b32.load_en, 0);
        b32.Run = 1'b1;
        b32.Mode = 1'b0;
        b32.Signed = 1'b0;
        c = 0;
        do begin
            tick;
            b32.Run = 1'b0;
            c++;
        end while (b32.Ready !== 1'b1 && c < 100);
        chk("w32_latency", c, mk(1'b0, 1'b0, 32).lat);
        chk("w32_idx_done", b32.step_idx, 31);
        b32.Ack = 1'b1;
        tick;
        b32.Ack = 1'b0;
        b32.Run = 1'b1;
        b32.Signed = 1'b1;
        c = 0;
        do begin
            tick;
            b32.Run = 1'b0;
            c++;
        end while (b32.Ready !== 1'b1 && c < 100);
        chk("w32_signed_latency", c, mk(1'b0, 1'b1, 32).lat);
        chk("w32_signed_q", b32.signed_q, 1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
